// File: rtl/sqrt_iter_pkg.sv
// Shared types and sizing helpers for the digit-by-digit square-root unit.
package sqrt_iter_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE_S} state_t;

  // Result bits produced for a Q(W-FRAC).FRAC radicand shifted left by FRAC.
  function automatic int calc_n(input int w, input int frac);
    return (w + frac) / 2;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 2);
  endfunction

endpackage

// File: rtl/sqrt_iter_step.sv
// One trial-subtract iteration of the square root: consumes two radicand bits
// and produces one root bit.
module sqrt_iter_step #(
  parameter int N = 12
) (
  input  logic [N+1:0] rem,
  input  logic [N-1:0] root,
  input  logic [1:0]   bits,
  output logic [N+1:0] rem_next,
  output logic [N-1:0] root_next
);

  logic [N+1:0] rem_sh;
  logic [N+1:0] trial;
  logic         ge;

  always_comb begin
    rem_sh    = (rem << 2) | (N+2)'(bits);
    trial     = {root, 2'b01};
    ge        = (rem_sh >= trial);
    rem_next  = ge ? (rem_sh - trial) : rem_sh;
    root_next = (root << 1) | N'(ge);
  end

endmodule

// File: rtl/sqrt_iter.sv
// Handshaked fixed-point unsigned square root, one result bit per clock.
// Define SQRT_ITER_ROUND_EN to run one extra guard iteration and round half-up.
module sqrt_iter
  import sqrt_iter_pkg::*;
#(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [W-1:0] DATA_IN,
  output logic         BUSY,
  output logic         DONE,
  output logic [W-1:0] DATA_OUT
);

  localparam int N = calc_n(W, FRAC);
`ifdef SQRT_ITER_ROUND_EN
  localparam int NI = N + 1;
`else
  localparam int NI = N;
`endif
  localparam int XW = 2 * NI;
  localparam int CW = cnt_w(NI);

  generate
    if (FRAC < 0 || FRAC >= W || ((W + FRAC) % 2) != 0) begin : g_bad_param
      $error("sqrt_iter: need 0 <= FRAC < W and (W+FRAC) even");
    end
  endgenerate

  state_t          state_q, state_d;
  logic [XW-1:0]   rad_q, rad_d;
  logic [NI+1:0]   rem_q, rem_d, rem_nx;
  logic [NI-1:0]   root_q, root_d, root_nx;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    out_q, out_d;
  logic [W-1:0]    res;

  sqrt_iter_step #(.N(NI)) u_step (
    .rem       (rem_q),
    .root      (root_q),
    .bits      (rad_q[XW-1 -: 2]),
    .rem_next  (rem_nx),
    .root_next (root_nx)
  );

`ifdef SQRT_ITER_ROUND_EN
  // LSB of the extended root is the guard bit; adding it rounds half-up.
  assign res = W'(root_nx[NI-1:1]) + W'(root_nx[0]);
`else
  assign res = W'(root_nx);
`endif

  always_comb begin
    state_d = state_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      IDLE, DONE_S: begin
        state_d = IDLE;
        if (START) begin
          rad_d   = XW'(DATA_IN) << (XW - W);
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = CW'(NI);
          state_d = CALC;
        end
      end
      CALC: begin
        rad_d  = rad_q << 2;
        rem_d  = rem_nx;
        root_d = root_nx;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          out_d   = res;
          state_d = DONE_S;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign BUSY     = (state_q == CALC);
  assign DONE     = (state_q == DONE_S);
  assign DATA_OUT = out_q;

endmodule

// File: tb/tb_sqrt_iter.sv
// Directed bench for sqrt_iter: default (16/8) and wide (24/12) instances.
module tb_sqrt_iter;

  localparam int W1 = 16, F1 = 8, W2 = 24, F2 = 12;
`ifdef SQRT_ITER_ROUND_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAT1 = (W1 + F1) / 2 + EXTRA;
  localparam int LAT2 = (W2 + F2) / 2 + EXTRA;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start1 = 1'b0, start2 = 1'b0;
  logic [W1-1:0] din1 = '0;
  logic [W2-1:0] din2 = '0;
  logic          busy1, done1, busy2, done2;
  logic [W1-1:0] dout1;
  logic [W2-1:0] dout2;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sqrt_iter #(.W(W1), .FRAC(F1)) u_dut (
    .CLK(clk), .RST(rst), .START(start1), .DATA_IN(din1),
    .BUSY(busy1), .DONE(done1), .DATA_OUT(dout1)
  );

  sqrt_iter #(.W(W2), .FRAC(F2)) u_dut_w (
    .CLK(clk), .RST(rst), .START(start2), .DATA_IN(din2),
    .BUSY(busy2), .DONE(done2), .DATA_OUT(dout2)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  function automatic longint isqrt(input longint x);
    longint lo = 0, hi = longint'(1) << 21, mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= x) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  function automatic logic [31:0] model(input int inst, input logic [31:0] d);
    longint x, r;
    x = longint'(d) << (inst != 0 ? F2 : F1);
`ifdef SQRT_ITER_ROUND_EN
    r = isqrt(x << 2);
    r = (r >> 1) + (r & 1);
`else
    r = isqrt(x);
`endif
    return r[31:0];
  endfunction

  function automatic logic [31:0] pick(input logic [31:0] trunc, input logic [31:0] rnd);
`ifdef SQRT_ITER_ROUND_EN
    return rnd;
`else
    return trunc;
`endif
  endfunction

  function automatic logic [15:0] b2b_val(input int c);
    return 16'(16'h0100 * (c + 1) + c * 7);
  endfunction

  // One operation: latency, busy width, result, DONE/BUSY exclusion, hold.
  task automatic run_op(input int inst, input logic [31:0] d, input logic [31:0] exp, input string tag);
    int n = 0, nb = 0;
    int lat = (inst != 0) ? LAT2 : LAT1;
    logic dn, bs;
    logic [31:0] q;
    @(negedge clk);
    if (inst != 0) begin start2 = 1'b1; din2 = d[23:0]; end
    else begin start1 = 1'b1; din1 = d[15:0]; end
    @(negedge clk);
    start1 = 1'b0; start2 = 1'b0;
    din1 = ~din1; din2 = ~din2;
    dn = 1'b0; bs = 1'b0;
    while (n < 200) begin
      dn = (inst != 0) ? done2 : done1;
      bs = (inst != 0) ? busy2 : busy1;
      if (dn) break;
      if (bs) nb++;
      @(negedge clk);
      n++;
    end
    q = (inst != 0) ? 32'(dout2) : 32'(dout1);
    chk({tag, "/lat"}, n, lat);
    chk({tag, "/busy_cyc"}, nb, lat);
    chk({tag, "/busy_at_done"}, bs, 1'b0);
    chk({tag, "/data"}, q, exp);
    repeat (2) @(negedge clk);
    chk({tag, "/hold"}, (inst != 0) ? 32'(dout2) : 32'(dout1), exp);
    chk({tag, "/done_pulse"}, (inst != 0) ? done2 : done1, 1'b0);
  endtask

  typedef struct {
    logic [31:0] din;
    logic [31:0] trunc;
    logic [31:0] rnd;
  } vec_t;

  vec_t vecs1[10] = '{
    '{32'h0400, 32'h0200, 32'h0200},
    '{32'h1E00, 32'h057A, 32'h057A},
    '{32'h6400, 32'h0A00, 32'h0A00},
    '{32'h0000, 32'h0000, 32'h0000},
    '{32'hFFFF, 32'h0FFF, 32'h1000},
    '{32'h0A00, 32'h0329, 32'h032A},
    '{32'h0001, 32'h0010, 32'h0010},
    '{32'h0002, 32'h0016, 32'h0017},
    '{32'h0200, 32'h016A, 32'h016A},
    '{32'h0100, 32'h0100, 32'h0100}
  };

  vec_t vecs2[5] = '{
    '{32'h004000, 32'h02000, 32'h02000},
    '{32'hFFFFFF, 32'h3FFFF, 32'h40000},
    '{32'h001000, 32'h01000, 32'h01000},
    '{32'h000000, 32'h00000, 32'h00000},
    '{32'h000002, 32'h0005A, 32'h0005B}
  };

  initial begin
    int dn_cnt;
    logic exp_done;
    logic [31:0] r;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst/busy", busy1, 1'b0);
    chk("rst/done", done1, 1'b0);
    chk("rst/dout", dout1, 32'h0);
    chk("rst/dout_w", dout2, 32'h0);
    rst = 1'b0;

    foreach (vecs1[i]) run_op(0, vecs1[i].din, pick(vecs1[i].trunc, vecs1[i].rnd), $sformatf("v16_%0h", vecs1[i].din));
    foreach (vecs2[i]) run_op(1, vecs2[i].din, pick(vecs2[i].trunc, vecs2[i].rnd), $sformatf("v24_%0h", vecs2[i].din));

    // Abort mid-calculation: reset during CALC, no DONE afterwards.
    run_op(0, 32'h1E00, 32'h057A, "pre_abort");
    @(negedge clk);
    start1 = 1'b1; din1 = 16'h6400;
    @(negedge clk);
    start1 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort/busy", busy1, 1'b0);
    chk("abort/dout", dout1, 32'h0);
    chk("abort/done", done1, 1'b0);
    rst = 1'b0;
    dn_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (done1) dn_cnt++;
    end
    chk("abort/no_done", dn_cnt, 0);
    run_op(0, 32'h0400, 32'h0200, "post_abort");

    // START held high with DATA_IN changing every cycle.
    @(negedge clk);
    start1 = 1'b1; din1 = b2b_val(0);
    for (int c = 0; c < 3 * (LAT1 + 1); c++) begin
      @(negedge clk);
      exp_done = ((c % (LAT1 + 1)) == LAT1);
      chk($sformatf("b2b_done_c%0d", c), done1, exp_done);
      chk($sformatf("b2b_busy_c%0d", c), busy1, !exp_done);
      if (exp_done) chk($sformatf("b2b_data_c%0d", c), dout1, model(0, 32'(b2b_val(c - LAT1))));
      din1 = b2b_val(c + 1);
    end
    start1 = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 120; i++) begin
      r = $urandom;
      run_op(0, 32'(r[15:0]), model(0, 32'(r[15:0])), $sformatf("rnd16_%0h", r[15:0]));
    end
    for (int i = 0; i < 60; i++) begin
      r = $urandom;
      run_op(1, 32'(r[23:0]), model(1, 32'(r[23:0])), $sformatf("rnd24_%0h", r[23:0]));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
